// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, binary index via pos2bin, and a sticky self-check alarm.
// Optional forced-release hold timer is built only when RR_ARB_TIMEOUT_EN is defined.

module pos2bin #(
    parameter int unsigned BIN_WIDTH = 4
) (
    input  logic [(1 << BIN_WIDTH)-1:0] pos,
    output logic [BIN_WIDTH-1:0]        bin,
    output logic                        err_multi_hot,
    output logic                        err_no_hot
);
    localparam int unsigned N = 1 << BIN_WIDTH;

    // OR of set-bit indices: exact for one-hot, flagged as multi-hot otherwise
    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pos[i]) begin
                bin = bin | BIN_WIDTH'(i);
            end
        end
    end

    assign err_no_hot    = (pos == '0);
    assign err_multi_hot = ((pos & (pos - N'(1))) != '0);
endmodule

module rr_onehot_arbiter #(
    parameter int unsigned BIN_WIDTH = 4,
    parameter int unsigned HOLD_MAX  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [(1 << BIN_WIDTH)-1:0] req,
    input  logic [(1 << BIN_WIDTH)-1:0] done,
    output logic [(1 << BIN_WIDTH)-1:0] grant,
    output logic [BIN_WIDTH-1:0]        grant_bin,
    output logic                        grant_valid,
    output logic                        timeout,
    output logic                        err_alarm
);
    localparam int unsigned N = 1 << BIN_WIDTH;

    if (BIN_WIDTH == 0 || HOLD_MAX == 0) begin : g_cfg_check
        $error("rr_onehot_arbiter: BIN_WIDTH and HOLD_MAX must both be >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [N-1:0]         grant_q, grant_nxt;
    logic [BIN_WIDTH-1:0] ptr, ptr_nxt, ptr_inc, scan_base, idx;
    logic [N-1:0]         sel_onehot;
    logic                 sel_any;
    logic                 err_multi_hot, err_no_hot;
    logic                 err_q, err_nxt;
    logic                 rel;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             forced;
    logic             timeout_q, timeout_nxt;
`endif

    pos2bin #(.BIN_WIDTH(BIN_WIDTH)) u_pos2bin (
        .pos           (grant_q),
        .bin           (grant_bin),
        .err_multi_hot (err_multi_hot),
        .err_no_hot    (err_no_hot)
    );

    assign grant       = grant_q;
    assign grant_valid = ~err_no_hot;
    assign err_alarm   = err_q;
    assign ptr_inc     = grant_bin + BIN_WIDTH'(1);

    // On a release edge the scan already starts past the outgoing grantee
    assign scan_base = (state == GRANT) ? ptr_inc : ptr;

    // Circular first-set-bit scan from scan_base
    always_comb begin
        sel_onehot = '0;
        sel_any    = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = scan_base + BIN_WIDTH'(i);
            if (!sel_any && req[idx]) begin
                sel_onehot[idx] = 1'b1;
                sel_any         = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        ptr_nxt   = ptr;
        rel       = 1'b0;
        err_nxt   = err_q | err_multi_hot | (err_no_hot && (state == GRANT));
`ifdef RR_ARB_TIMEOUT_EN
        cnt_nxt     = cnt;
        forced      = 1'b0;
        timeout_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sel_any) begin
                    grant_nxt = sel_onehot;
                    state_nxt = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            GRANT: begin
                rel = done[grant_bin] || !req[grant_bin];
`ifdef RR_ARB_TIMEOUT_EN
                // done wins over the timer, so timeout only fires on a pure hold expiry
                forced      = !rel && (cnt == CNT_W'(HOLD_MAX));
                timeout_nxt = forced;
                rel         = rel || forced;
                cnt_nxt     = cnt + CNT_W'(1);
`endif
                if (rel) begin
                    ptr_nxt = ptr_inc;
                    if (sel_any) begin
                        grant_nxt = sel_onehot;
`ifdef RR_ARB_TIMEOUT_EN
                        cnt_nxt   = '0;
`endif
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_q   <= '0;
            ptr       <= '0;
            err_q     <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt       <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            ptr       <= ptr_nxt;
            err_q     <= err_nxt;
`ifdef RR_ARB_TIMEOUT_EN
            cnt       <= cnt_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: directed scenarios plus random traffic against a round-robin reference model.
module tb_rr_onehot_arbiter;
    localparam int unsigned BW   = 4;
    localparam int unsigned N    = 16;
    localparam int unsigned HOLD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, done, grant;
    logic [BW-1:0] grant_bin;
    logic          grant_valid, timeout, err_alarm;

    int checks   = 0;
    int failures = 0;

    // Reference model: current grantee (-1 = none), priority pointer, hold count, timeout flag
    int m_cur = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_to  = 1'b0;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.BIN_WIDTH(BW), .HOLD_MAX(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_bin   (grant_bin),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .err_alarm   (err_alarm)
    );

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        bit rl;
        m_to = 1'b0;
        if (m_cur < 0) begin
            m_cur = pick(r, m_ptr);
            m_cnt = 0;
        end else begin
            rl = d[m_cur] || !r[m_cur];
`ifdef RR_ARB_TIMEOUT_EN
            if (!rl && m_cnt == HOLD) begin
                rl   = 1'b1;
                m_to = 1'b1;
            end
`endif
            if (rl) begin
                m_ptr = (m_cur + 1) % N;
                m_cur = pick(r, m_ptr);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        done = '0;
        m_cur = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; done = '0;
        #1;
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL reset_grant got=%h exp=%h", grant, 16'h0000); end
        checks++; if (grant_bin !== 4'd0) begin failures++; $display("FAIL reset_bin got=%0d exp=0", grant_bin); end
        checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        checks++; if (err_alarm !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_alarm); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        tick(16'h0001, 16'h0000);
        checks++; if (grant !== 16'h0001) begin failures++; $display("FAIL single_grant got=%h exp=0001", grant); end
        checks++; if (grant_bin !== 4'd0) begin failures++; $display("FAIL single_bin got=%0d exp=0", grant_bin); end
        checks++; if (grant_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", grant_valid); end
        tick(16'h0000, 16'h0001);
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL single_release got=%h exp=0000", grant); end
        checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL single_release_valid got=%b exp=0", grant_valid); end
        tick(16'h0000, 16'hFFFF);
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL idle_done_ignored got=%h exp=0000", grant); end
        tick(16'h0003, 16'h0000);
        checks++; if (grant !== 16'h0002) begin failures++; $display("FAIL ptr_advanced got=%h exp=0002", grant); end
    endtask

    task automatic test_back_to_back();
        int exp_bin;
        apply_reset();
        tick(16'hFFFF, 16'h0000);
        for (int i = 0; i <= 16; i++) begin
            exp_bin = i % 16;
            checks++; if (grant_bin !== BW'(exp_bin) || grant_valid !== 1'b1) begin
                failures++; $display("FAIL b2b_seq step=%0d got=%0d/%b exp=%0d/1", i, grant_bin, grant_valid, exp_bin);
            end
            for (int h = 0; h < 2; h++) begin
                tick(16'hFFFF, 16'h0000);
                checks++; if (grant_bin !== BW'(exp_bin)) begin
                    failures++; $display("FAIL b2b_hold step=%0d got=%0d exp=%0d", i, grant_bin, exp_bin);
                end
            end
            tick(16'hFFFF, N'(1) << exp_bin);
        end
    endtask

    task automatic test_wrap_release();
        apply_reset();
        tick(16'h8001, 16'h0000);
        checks++; if (grant !== 16'h0001) begin failures++; $display("FAIL wrap_first got=%h exp=0001", grant); end
        tick(16'h8000, 16'h0008);
        checks++; if (grant !== 16'h8000 || grant_bin !== 4'd15) begin
            failures++; $display("FAIL wrap_req_drop got=%h/%0d exp=8000/15", grant, grant_bin);
        end
        tick(16'h8000, 16'h0008);
        checks++; if (grant !== 16'h8000) begin failures++; $display("FAIL foreign_done got=%h exp=8000", grant); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(16'h0010, 16'h0000);
        checks++; if (grant !== 16'h0010) begin failures++; $display("FAIL areset_setup got=%h exp=0010", grant); end
        @(negedge clk);
        #1 rst = 1'b1;
        m_cur = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
        #1;
        checks++; if (grant !== 16'h0000 || grant_valid !== 1'b0 || err_alarm !== 1'b0) begin
            failures++; $display("FAIL areset_immediate got=%h/%b/%b exp=0000/0/0", grant, grant_valid, err_alarm);
        end
        #4 rst = 1'b0;
        tick(16'h0030, 16'h0000);
        checks++; if (grant !== 16'h0010) begin failures++; $display("FAIL areset_restart got=%h exp=0010", grant); end
    endtask

    task automatic test_self_check();
        apply_reset();
        tick(16'h0001, 16'h0000);
        checks++; if (err_alarm !== 1'b0) begin failures++; $display("FAIL selfchk_pre got=%b exp=0", err_alarm); end
        @(negedge clk);
        force dut.grant_q = 16'h0011;
        @(posedge clk);
        #1;
        checks++; if (err_alarm !== 1'b1) begin failures++; $display("FAIL selfchk_set got=%b exp=1", err_alarm); end
        @(negedge clk);
        release dut.grant_q;
        for (int i = 0; i < 3; i++) begin
            tick(16'h0000, 16'h0000);
            checks++; if (err_alarm !== 1'b1) begin failures++; $display("FAIL selfchk_sticky cyc=%0d got=%b exp=1", i, err_alarm); end
        end
        apply_reset();
        #1;
        checks++; if (err_alarm !== 1'b0) begin failures++; $display("FAIL selfchk_clear got=%b exp=0", err_alarm); end
    endtask

    task automatic test_timeout();
        apply_reset();
        tick(16'h0003, 16'h0000);
`ifdef RR_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick(16'h0003, 16'h0000);
            checks++; if (grant !== 16'h0001 || timeout !== 1'b0) begin
                failures++; $display("FAIL to_hold cyc=%0d got=%h/%b exp=0001/0", c, grant, timeout);
            end
        end
        tick(16'h0003, 16'h0000);
        checks++; if (grant !== 16'h0002 || timeout !== 1'b1) begin
            failures++; $display("FAIL to_fire got=%h/%b exp=0002/1", grant, timeout);
        end
        tick(16'h0003, 16'h0000);
        checks++; if (grant !== 16'h0002 || timeout !== 1'b0) begin
            failures++; $display("FAIL to_pulse got=%h/%b exp=0002/0", grant, timeout);
        end
`else
        for (int c = 0; c < 1000; c++) begin
            tick(16'h0003, 16'h0000);
            checks++; if (grant !== 16'h0001 || timeout !== 1'b0) begin
                failures++; $display("FAIL no_to_hold cyc=%0d got=%h/%b exp=0001/0", c, grant, timeout);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [N-1:0]  r, d, eg;
        logic [BW-1:0] eb;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            r = N'($urandom & $urandom);
            if ($urandom_range(7) == 0) r = '0;
            d = '0;
            if ($urandom_range(1) == 0 && m_cur >= 0) d = N'(1) << m_cur;
            if ($urandom_range(2) == 0) d = d | N'($urandom & $urandom & $urandom);
            tick(r, d);
            eg = (m_cur < 0) ? '0 : (N'(1) << m_cur);
            eb = (m_cur < 0) ? '0 : BW'(m_cur);
            checks++; if (grant !== eg) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%h exp=%h", i, grant, eg); end
            checks++; if (grant_bin !== eb) begin failures++; $display("FAIL rnd_bin cyc=%0d got=%0d exp=%0d", i, grant_bin, eb); end
            checks++; if (grant_valid !== (m_cur >= 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, grant_valid, m_cur >= 0); end
            checks++; if (timeout !== m_to) begin failures++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", i, timeout, m_to); end
            checks++; if (err_alarm !== 1'b0) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=0", i, err_alarm); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap_release();
        test_async_reset();
        test_self_check();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
